// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, transaction
// owner codes and default sizing.
package pipeline_mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // True when 'who' owns a transaction that is still in flight.
  function automatic logic owns_txn(input state_e st, input owner_e own, input owner_e who);
    return (st != ST_IDLE) && (own == who);
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around the arbiter.
// slave: the arbiter's view. master: the view of the surrounding pipeline/memory.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // fetch side
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;
  // data side
  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [DATA_W/8-1:0]   dm_be_i;
  logic [ADDR_W-1:0]     dm_addr_i;
  logic [DATA_W-1:0]     dm_wdata_i;
  logic                  dm_gnt_o;
  logic                  dm_rvalid_o;
  logic [DATA_W-1:0]     dm_rdata_o;
  // memory port
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;
  // status
  logic                  protocol_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output protocol_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  protocol_err_o
  );

endinterface

// File: rtl/pipeline_mem_arbiter_arb_select.sv
// Priority pick between fetch and data requests. Data normally wins, but
// after STARVE_MAX consecutive data grants against a waiting fetch, fetch
// is forced through once.
module arb_select
  import pipeline_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic if_req,
  input  logic dm_req,
  input  logic idle,
  output logic pick_if,
  output logic pick_dm
);

  // Width sized so the counter can hold STARVE_MAX itself (and stays >= 1 bit).
  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;

  // Grant selection; only offered while the arbiter is idle.
  always_comb begin
    pick_if = 1'b0;
    pick_dm = 1'b0;
    if (idle) begin
      if (dm_req && (!if_req || (starve_cnt_r < CNT_MAX))) begin
        pick_dm = 1'b1;
      end else if (if_req) begin
        pick_if = 1'b1;
      end else begin
        pick_if = 1'b0;
      end
    end else begin
      pick_dm = 1'b0;
    end
  end

  // Count data grants that bypass a waiting fetch; saturate at STARVE_MAX.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!if_req || pick_if) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (pick_dm && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the memory
// stage. One transaction in flight at a time: IDLE grants and captures the
// request, REQ presents it until the memory accepts, RESP waits for the
// response, which is routed back to whichever side issued it.
module pipeline_mem_arbiter
  import pipeline_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  pipeline_mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_r;
  state_e              state_n;
  owner_e              owner_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [BE_W-1:0]     mem_be_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                protocol_err_r;
  logic                pick_if_s;
  logic                pick_dm_s;
  logic                idle_s;
  logic                if_owns_s;
  logic                dm_owns_s;

  // Grants are withheld while reset is asserted so every output reads 0.
  assign idle_s = (state_r == ST_IDLE) && !reset_i;

  arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_select (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .if_req  (bus.if_req_i),
    .dm_req  (bus.dm_req_i),
    .idle    (idle_s),
    .pick_if (pick_if_s),
    .pick_dm (pick_dm_s)
  );

  // Next-state logic for the single-outstanding transaction sequence.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_if_s || pick_dm_s) begin
          state_n = ST_REQ;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt_i) begin
          state_n = bus.mem_rvalid_i ? ST_IDLE : ST_RESP;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid_i) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Capture the granted request and its owner; fields stay frozen until the next grant.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_r     <= OWN_NONE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_req_r <= (state_n == ST_REQ);
      if (pick_dm_s) begin
        owner_r     <= OWN_DM;
        mem_we_r    <= bus.dm_we_i;
        mem_be_r    <= bus.dm_be_i;
        mem_addr_r  <= bus.dm_addr_i;
        mem_wdata_r <= bus.dm_wdata_i;
      end else if (pick_if_s) begin
        owner_r     <= OWN_IF;
        mem_we_r    <= 1'b0;
        mem_be_r    <= {BE_W{1'b1}};
        mem_addr_r  <= bus.if_addr_i;
        mem_wdata_r <= {DATA_W{1'b0}};
      end else if (state_n == ST_IDLE) begin
        owner_r <= OWN_NONE;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  // Sticky flag for a memory response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      protocol_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.mem_rvalid_i) begin
      protocol_err_r <= 1'b1;
    end else begin
      protocol_err_r <= protocol_err_r;
    end
  end

  assign if_owns_s = owns_txn(state_r, owner_r, OWN_IF);
  assign dm_owns_s = owns_txn(state_r, owner_r, OWN_DM);

  assign bus.if_gnt_o       = pick_if_s;
  assign bus.dm_gnt_o       = pick_dm_s;
  assign bus.if_rvalid_o    = bus.mem_rvalid_i && if_owns_s;
  assign bus.dm_rvalid_o    = bus.mem_rvalid_i && dm_owns_s;
  assign bus.if_rdata_o     = if_owns_s ? bus.mem_rdata_i : {DATA_W{1'b0}};
  assign bus.dm_rdata_o     = dm_owns_s ? bus.mem_rdata_i : {DATA_W{1'b0}};
  assign bus.mem_req_o      = mem_req_r;
  assign bus.mem_we_o       = mem_we_r;
  assign bus.mem_be_o       = mem_be_r;
  assign bus.mem_addr_o     = mem_addr_r;
  assign bus.mem_wdata_o    = mem_wdata_r;
  assign bus.protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench for pipeline_mem_arbiter. Inputs change on the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_pipeline_mem_arbiter;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk_i = ~clk_i;

  pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic quiet_inputs();
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'h0;
    bus.dm_addr_i = 32'h0; bus.dm_wdata_i = 32'h0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
  endtask

  // Zero-wait completion of the transaction granted in the previous cycle.
  task automatic complete_now(input logic [31:0] rd);
    @(negedge clk_i);
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = rd;
    @(negedge clk_i);
    quiet_inputs();
  endtask

  task automatic test_reset();
    quiet_inputs();
    reset_i = 1'b1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o, bus.dm_gnt_o, bus.dm_rvalid_o,
           bus.dm_rdata_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
           bus.mem_wdata_o, bus.protocol_err_o} !== 140'h0) begin
        bad++; $display("FAIL reset_outputs: cycle %0d some output nonzero, gnt=%b req=%b", i, bus.if_gnt_o, bus.mem_req_o);
      end
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    total++;
    if (bus.if_gnt_o !== 1'b1) begin
      bad++; $display("FAIL reset_first_gnt: if_gnt_o=%b want 1", bus.if_gnt_o);
    end
    complete_now(32'h1);
  endtask

  task automatic test_fetch_only();
    @(negedge clk_i);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    #1;
    total++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b10) begin
      bad++; $display("FAIL fetch_gnt: got %b want 10", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    @(negedge clk_i);
    bus.if_req_i = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h00500093;
    #1;
    total++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      bad++; $display("FAIL fetch_mem: req=%b we=%b be=%h addr=%h want 1 0 f 100",
                      bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
    end
    total++;
    if ({bus.if_rvalid_o, bus.if_rdata_o, bus.dm_rvalid_o, bus.dm_rdata_o} !== {1'b1, 32'h00500093, 1'b0, 32'h0}) begin
      bad++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h dm_rvalid=%b want 1 00500093 0",
                      bus.if_rvalid_o, bus.if_rdata_o, bus.dm_rvalid_o);
    end
    @(negedge clk_i);
    quiet_inputs();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    #1;
    total++;
    if (bus.if_gnt_o !== 1'b1) begin
      bad++; $display("FAIL fetch_idle_again: if_gnt_o=%b want 1", bus.if_gnt_o);
    end
    complete_now(32'h2);
  endtask

  task automatic test_both_same_cycle();
    @(negedge clk_i);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'b0011;
    bus.dm_addr_i = 32'h200; bus.dm_wdata_i = 32'hDEADBEEF;
    #1;
    total++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b01) begin
      bad++; $display("FAIL both_first: got %b want 01", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    @(negedge clk_i);
    bus.dm_req_i = 1'b0; bus.dm_addr_i = 32'h999;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
    #1;
    total++;
    if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 4'b0011, 32'h200, 32'hDEADBEEF}) begin
      bad++; $display("FAIL both_store: we=%b be=%b addr=%h wdata=%h", bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    total++;
    if ({bus.if_gnt_o, bus.dm_rvalid_o, bus.if_rvalid_o} !== 3'b010) begin
      bad++; $display("FAIL both_ack: if_gnt/dm_rvalid/if_rvalid=%b want 010", {bus.if_gnt_o, bus.dm_rvalid_o, bus.if_rvalid_o});
    end
    @(negedge clk_i);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    #1;
    total++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b10) begin
      bad++; $display("FAIL both_second: got %b want 10", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    complete_now(32'h3);
  endtask

  task automatic test_starvation();
    int   streak = 0;
    logic [1:0] want;
    logic [31:0] rd;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk_i);
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
      bus.if_req_i = 1'b1; bus.if_addr_i = $urandom;
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = $urandom;
      // Fetch gets through once data has won four times in a row.
      if (streak < 4) begin want = 2'b01; streak++; end
      else begin want = 2'b10; streak = 0; end
      #1;
      total++;
      if ({bus.if_gnt_o, bus.dm_gnt_o} !== want) begin
        bad++; $display("FAIL starve_order: grant %0d got %b want %b", g, {bus.if_gnt_o, bus.dm_gnt_o}, want);
      end
      @(negedge clk_i);
      rd = $urandom;
      bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = rd;
      #1;
      total++;
      if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_gnt_o, bus.dm_gnt_o} !== {want, 2'b00}) begin
        bad++; $display("FAIL starve_route: grant %0d got %b want %b00", g,
                        {bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_gnt_o, bus.dm_gnt_o}, want);
      end
    end
    @(negedge clk_i);
    quiet_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] a = 32'h0000_0A40;
    logic [31:0] rd = 32'h1234_5678;
    int pulses = 0;
    @(negedge clk_i);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = a;
    #1;
    total++;
    if (bus.dm_gnt_o !== 1'b1) begin
      bad++; $display("FAIL stall_gnt: dm_gnt_o=%b want 1", bus.dm_gnt_o);
    end
    // Phases after the grant: 3 stalled REQ, REQ+gnt, RESP idle, RESP+rvalid.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      bus.dm_addr_i = $urandom; bus.dm_we_i = 1'b1;
      bus.mem_gnt_i = (c == 3); bus.mem_rvalid_i = (c == 5); bus.mem_rdata_i = rd;
      #1;
      if (bus.dm_rvalid_o) pulses++;
      total++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o} !==
          {(c <= 3), 1'b0, a, 3'b000}) begin
        bad++; $display("FAIL stall_hold: cycle %0d req=%b we=%b addr=%h gnt=%b%b if_rvalid=%b", c,
                        bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o);
      end
    end
    total++;
    if (pulses != 1 || bus.dm_rdata_o !== rd) begin
      bad++; $display("FAIL stall_resp: pulses=%0d rdata=%h want 1 %h", pulses, bus.dm_rdata_o, rd);
    end
    @(negedge clk_i);
    bus.dm_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.if_gnt_o !== 1'b1) begin
      bad++; $display("FAIL stall_after: if_gnt_o=%b want 1", bus.if_gnt_o);
    end
    complete_now(32'h4);
  endtask

  task automatic test_protocol_err();
    @(negedge clk_i); #1;
    total++;
    if (bus.protocol_err_o !== 1'b0) begin
      bad++; $display("FAIL perr_clean: protocol_err_o=%b want 0", bus.protocol_err_o);
    end
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0000;
    #1;
    total++;
    if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o, bus.dm_rdata_o} !== 66'h0) begin
      bad++; $display("FAIL perr_route: if_rvalid=%b dm_rvalid=%b want 0 0", bus.if_rvalid_o, bus.dm_rvalid_o);
    end
    @(negedge clk_i);
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h8;
    #1;
    total++;
    if (bus.protocol_err_o !== 1'b1) begin
      bad++; $display("FAIL perr_set: protocol_err_o=%b want 1", bus.protocol_err_o);
    end
    complete_now(32'h5);
    #1;
    total++;
    if (bus.protocol_err_o !== 1'b1) begin
      bad++; $display("FAIL perr_sticky: protocol_err_o=%b want 1", bus.protocol_err_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    total++;
    if (bus.protocol_err_o !== 1'b0) begin
      bad++; $display("FAIL perr_clear: protocol_err_o=%b want 0", bus.protocol_err_o);
    end
  endtask

  // Random traffic against a transaction-level model: pending requests,
  // one outstanding memory access, data-first priority with fetch forced
  // after four consecutive bypasses.
  task automatic test_random();
    int busy = 0;          // 0 free, 1 waiting for acceptance, 2 waiting for response
    int own = 0;           // 1 fetch, 2 data
    int sc = 0;
    bit if_pend = 0, dm_pend = 0, mg, mr, dm_we = 0, e_we = 0;
    logic [31:0] if_a = 0, dm_a = 0, dm_wd = 0, e_addr = 0, e_wd = 0, rd;
    logic [3:0]  dm_be = 0, e_be = 0;
    logic [1:0]  want;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i);
      if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_a = $urandom; end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1; dm_a = $urandom; dm_wd = $urandom; dm_we = $urandom_range(0, 1); dm_be = 4'($urandom);
      end
      bus.if_req_i = if_pend; bus.if_addr_i = if_pend ? if_a : $urandom;
      bus.dm_req_i = dm_pend; bus.dm_addr_i = dm_pend ? dm_a : $urandom;
      bus.dm_wdata_i = dm_pend ? dm_wd : $urandom; bus.dm_we_i = dm_pend ? dm_we : 1'($urandom);
      bus.dm_be_i = dm_pend ? dm_be : 4'($urandom);
      mg = 0; mr = 0;
      if (busy == 1) begin mg = $urandom_range(0, 1); mr = mg ? 1'($urandom_range(0, 1)) : 1'b0; end
      else if (busy == 2) mr = $urandom_range(0, 1);
      rd = $urandom;
      bus.mem_gnt_i = mg; bus.mem_rvalid_i = mr; bus.mem_rdata_i = rd;
      #1;
      want = 2'b00;
      if (busy == 0) begin
        if (dm_pend && (!if_pend || sc < 4)) want = 2'b01;
        else if (if_pend) want = 2'b10;
      end
      total++;
      if ({bus.if_gnt_o, bus.dm_gnt_o} !== want) begin
        bad++; $display("FAIL rand_gnt: cycle %0d got %b want %b", cyc, {bus.if_gnt_o, bus.dm_gnt_o}, want);
      end
      if (busy != 0) begin
        total++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {(busy == 1), e_we, e_be, e_addr} ||
            (own == 2 && bus.mem_wdata_o !== e_wd)) begin
          bad++; $display("FAIL rand_mem: cycle %0d req=%b we=%b be=%h addr=%h wdata=%h want %0d %b %h %h %h", cyc,
                          bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o,
                          busy == 1, e_we, e_be, e_addr, e_wd);
        end
      end
      total++;
      if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o, bus.dm_rdata_o} !==
          {mr && own == 1, mr && own == 2, (busy != 0 && own == 1) ? rd : 32'h0, (busy != 0 && own == 2) ? rd : 32'h0}) begin
        bad++; $display("FAIL rand_resp: cycle %0d rvalid=%b%b if_rdata=%h dm_rdata=%h owner=%0d busy=%0d", cyc,
                        bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o, bus.dm_rdata_o, own, busy);
      end
      if (!if_pend || want == 2'b10) sc = 0;
      else if (want == 2'b01 && sc < 4) sc++;
      if (busy == 0 && want == 2'b01) begin
        busy = 1; own = 2; dm_pend = 0; e_we = dm_we; e_be = dm_be; e_addr = dm_a; e_wd = dm_wd;
      end else if (busy == 0 && want == 2'b10) begin
        busy = 1; own = 1; if_pend = 0; e_we = 0; e_be = 4'hF; e_addr = if_a;
      end else if (busy == 1 && mg) begin
        busy = mr ? 0 : 2;
      end else if (busy == 2 && mr) begin
        busy = 0;
      end
      if (busy == 0) own = 0;
    end
    @(negedge clk_i);
    quiet_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_both_same_cycle();
    test_starvation();
    test_stall();
    test_protocol_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
